// File: rtl/alu16_pkg.sv
// Shared constants for the 16-bit issue ALU: function codes, FSM states and
// the per-function ALU control tuples.
package alu16_pkg;

   localparam int WIDTH = 16;

   localparam logic [3:0] FN_AND  = 4'd0;
   localparam logic [3:0] FN_OR   = 4'd1;
   localparam logic [3:0] FN_ADD  = 4'd2;
   localparam logic [3:0] FN_SUB  = 4'd3;
   localparam logic [3:0] FN_SLT  = 4'd4;
   localparam logic [3:0] FN_NOR  = 4'd5;
   localparam logic [3:0] FN_ADDC = 4'd6;
   localparam logic [3:0] FN_SUBB = 4'd7;

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_OR  = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_SLT = 3'd3;
   localparam logic [2:0] OP_NOR = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // use_carry replaces the fixed cin with the stored carry (ADDC/SUBB);
   // arith marks the functions whose carry/overflow are architecturally visible.
   typedef struct packed {
      logic [2:0] op;
      logic       bnegate;
      logic       cin;
      logic       use_carry;
      logic       arith;
      logic       legal;
   } alu_ctl_t;

   localparam alu_ctl_t CTL_AND     = '{OP_AND, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam alu_ctl_t CTL_OR      = '{OP_OR,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam alu_ctl_t CTL_ADD     = '{OP_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   localparam alu_ctl_t CTL_SUB     = '{OP_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
   localparam alu_ctl_t CTL_SLT     = '{OP_SLT, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
   localparam alu_ctl_t CTL_NOR     = '{OP_NOR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam alu_ctl_t CTL_ADDC    = '{OP_ADD, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   localparam alu_ctl_t CTL_SUBB    = '{OP_ADD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
   localparam alu_ctl_t CTL_ILLEGAL = '{OP_AND, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   function automatic alu_ctl_t decode_funct(input logic [3:0] funct);
      case (funct)
         FN_AND:  return CTL_AND;
         FN_OR:   return CTL_OR;
         FN_ADD:  return CTL_ADD;
         FN_SUB:  return CTL_SUB;
         FN_SLT:  return CTL_SLT;
         FN_NOR:  return CTL_NOR;
         FN_ADDC: return CTL_ADDC;
         FN_SUBB: return CTL_SUBB;
         default: return CTL_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/from1_to16.sv
// Purely combinational 16-bit ALU: AND/OR/NOR, add with optional b inversion
// and carry-in, and signed set-less-than built on the adder.
module from1_to16
   import alu16_pkg::*;
(
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [2:0]       op_i,
   input  logic             bnegate_i,
   input  logic             cin_i,
   output logic [WIDTH-1:0] result_o,
   output logic             cout_o,
   output logic             ovf_o
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic             ovf;

   always_comb begin
      b_eff = bnegate_i ? ~b_i : b_i;
      sum   = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_i};
      ovf   = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
   end

   // NOTE: every output of a combinational block gets a default first so no
   // path through the case leaves it unassigned and infers a latch.
   always_comb begin
      result_o = '0;
      cout_o   = sum[WIDTH];
      ovf_o    = ovf;
      case (op_i)
         OP_AND:  result_o = a_i & b_eff;
         OP_OR:   result_o = a_i | b_eff;
         OP_ADD:  result_o = sum[WIDTH-1:0];
         OP_SLT:  result_o = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
         OP_NOR:  result_o = ~(a_i | b_eff);
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/alu16_issue.sv
// Single-issue ALU wrapper: accepts one command, executes it on registered
// operands, and holds the registered result until the consumer takes it.
module alu16_issue
   import alu16_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_funct,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_zero,
   output logic             res_neg,
   output logic             res_carry,
   output logic             res_ovf,
   output logic             res_err
);

   state_t           state_q, state_d;
   logic [3:0]       funct_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] data_q, data_d;
   logic             zero_q, zero_d;
   logic             neg_q, neg_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             err_q, err_d;
   logic             stored_c_q;

   alu_ctl_t         ctl;
   logic [WIDTH-1:0] alu_result;
   logic             alu_cout, alu_ovf;
   logic             accept;

   // Handshake outputs are forced low while reset is held, even before the
   // synchronous reset has reached the state register.
   assign cmd_ready = !rst && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && res_ready));
   assign res_valid = !rst && (state_q == ST_DONE);
   assign accept    = cmd_valid && cmd_ready;

   assign ctl = decode_funct(funct_q);

   from1_to16 u_alu (
      .a_i       (a_q),
      .b_i       (b_q),
      .op_i      (ctl.op),
      .bnegate_i (ctl.bnegate),
      .cin_i     (ctl.use_carry ? stored_c_q : ctl.cin),
      .result_o  (alu_result),
      .cout_o    (alu_cout),
      .ovf_o     (alu_ovf)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_DONE;
         ST_DONE: if (res_ready) state_d = cmd_valid ? ST_EXEC : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      data_d  = alu_result;
      zero_d  = (alu_result == '0);
      neg_d   = alu_result[WIDTH-1];
      carry_d = ctl.arith && alu_cout;
      ovf_d   = ctl.arith && alu_ovf;
      err_d   = 1'b0;
      if (!ctl.legal) begin
         data_d = '0;
         zero_d = 1'b1;
         neg_d  = 1'b0;
         err_d  = 1'b1;
      end
   end

   // NOTE: registers take non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         funct_q    <= '0;
         a_q        <= '0;
         b_q        <= '0;
         data_q     <= '0;
         zero_q     <= 1'b0;
         neg_q      <= 1'b0;
         carry_q    <= 1'b0;
         ovf_q      <= 1'b0;
         err_q      <= 1'b0;
         stored_c_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            funct_q <= cmd_funct;
            a_q     <= cmd_a;
            b_q     <= cmd_b;
         end
         if (state_q == ST_EXEC) begin
            data_q  <= data_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            if (ctl.arith) stored_c_q <= carry_d;
         end
      end
   end

   assign res_data  = data_q;
   assign res_zero  = zero_q;
   assign res_neg   = neg_q;
   assign res_carry = carry_q;
   assign res_ovf   = ovf_q;
   assign res_err   = err_q;

endmodule
